// File: rtl/decode_stage.sv
// Registered decode stage for the 20-bit SuperSpeed ISA: combinational decode feeding a
// main output register backed by a one-entry skid register, plus halt lock, flush and counter.
module decode_stage #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [19:0]       in_instr,
  input  logic [ADDR_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [2:0]        alu_select,
  output logic              alu,
  output logic              is_imm,
  output logic              ld,
  output logic              st,
  output logic              push,
  output logic              pop,
  output logic              jump,
  output logic              be,
  output logic              be_select,
  output logic              halt,
  output logic              illegal,
  output logic [3:0]        dr,
  output logic [3:0]        sr1,
  output logic [3:0]        sr2,
  output logic [DATA_W-1:0] imm,
  output logic [ADDR_W-1:0] addr,
  output logic              halted,
  output logic [CNT_W-1:0]  decode_count
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [2:0]        alu_select;
    logic              alu;
    logic              is_imm;
    logic              ld;
    logic              st;
    logic              push;
    logic              pop;
    logic              jump;
    logic              be;
    logic              be_select;
    logic              halt;
    logic              illegal;
    logic [3:0]        dr;
    logic [3:0]        sr1;
    logic [3:0]        sr2;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [4:0]         op;
  logic               is_alu;
  logic               regform;
  logic signed [6:0]  imm7;
  logic [ADDR_W+9:0]  addr_be_ext;
  logic [ADDR_W+9:0]  addr_abs_ext;
  entry_t             dec;

  entry_t             main_q, main_d;
  entry_t             skid_q, skid_d;
  logic               main_vld_q, main_vld_d;
  logic               skid_vld_q, skid_vld_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic               xfer;

  assign op           = in_instr[19:15];
  assign is_alu       = (op >= 5'd1) && (op <= 5'd10);
  assign regform      = is_alu & op[0];
  assign imm7         = in_instr[6:0];
  // Widen first, then keep the low ADDR_W bits: zero-extends or truncates for any ADDR_W.
  assign addr_be_ext  = {{(ADDR_W + 3){1'b0}}, in_instr[6:0]};
  assign addr_abs_ext = {{ADDR_W{1'b0}}, in_instr[9:0]};

  // NOTE: every field gets a default before the case logic so no latch is inferred.
  always_comb begin
    dec            = '0;
    dec.pc         = in_pc;
    dec.halt       = (op == 5'd0);
    dec.alu        = is_alu;
    dec.is_imm     = is_alu & ~op[0];
    if (is_alu) begin
      dec.alu_select = {op > 5'd8,
                        (op >= 5'd5) && (op <= 5'd8),
                        (op == 5'd3) || (op == 5'd4) || (op == 5'd7) || (op == 5'd8)};
    end
    dec.ld         = (op == 5'd11);
    dec.st         = (op == 5'd12);
    dec.push       = (op == 5'd13);
    dec.pop        = (op == 5'd14);
    dec.jump       = (op == 5'd15);
    dec.be         = (op == 5'd16) || (op == 5'd17);
    dec.be_select  = (op == 5'd16);
    dec.illegal    = (op >= 5'd18);

    if (dec.pop)       dec.dr = in_instr[3:0];
    else if (dec.ld)   dec.dr = in_instr[13:10];
    else if (regform)  dec.dr = in_instr[11:8];
    else               dec.dr = in_instr[14:11];

    if (dec.push)        dec.sr1 = in_instr[3:0];
    else if (regform)    dec.sr1 = in_instr[7:4];
    else if (dec.is_imm) dec.sr1 = in_instr[10:7];
    else if (dec.st)     dec.sr1 = in_instr[13:10];
    else                 dec.sr1 = in_instr[14:11];

    dec.sr2  = regform ? in_instr[3:0] : in_instr[10:7];
    dec.imm  = DATA_W'(imm7);
    dec.addr = dec.be ? addr_be_ext[ADDR_W-1:0] : addr_abs_ext[ADDR_W-1:0];
  end

  assign in_ready = ~skid_vld_q & ~halted_q & ~flush;
  assign accept   = in_valid & in_ready;
  assign xfer     = main_vld_q & out_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    halted_d   = halted_q;
    cnt_d      = cnt_q;

    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
      halted_d   = 1'b0;
    end else begin
      if (xfer && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (accept && dec.halt) halted_d = 1'b1;

      if (xfer || !main_vld_q) begin
        // Main frees up this cycle; a waiting skid entry always goes first to keep order.
        if (skid_vld_q) begin
          main_d     = skid_q;
          main_vld_d = 1'b1;
          skid_vld_d = 1'b0;
        end else begin
          main_vld_d = accept;
          if (accept) main_d = dec;
        end
      end else if (accept) begin
        skid_d     = dec;
        skid_vld_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the data registers are
  // reset too because the decoded fields must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid    = main_vld_q;
  assign out_pc       = main_q.pc;
  assign alu_select   = main_q.alu_select;
  assign alu          = main_q.alu;
  assign is_imm       = main_q.is_imm;
  assign ld           = main_q.ld;
  assign st           = main_q.st;
  assign push         = main_q.push;
  assign pop          = main_q.pop;
  assign jump         = main_q.jump;
  assign be           = main_q.be;
  assign be_select    = main_q.be_select;
  assign halt         = main_q.halt;
  assign illegal      = main_q.illegal;
  assign dr           = main_q.dr;
  assign sr1          = main_q.sr1;
  assign sr2          = main_q.sr2;
  assign imm          = main_q.imm;
  assign addr         = main_q.addr;
  assign halted       = halted_q;
  assign decode_count = cnt_q;

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode pipeline stage for the 20-bit SuperSpeed ISA. It accepts raw instructions and a PC tag over a valid/ready handshake, decodes them into control strobes and register/immediate/address fields, and presents the result one cycle later through a 2-entry skid buffer. Beyond the pure decode, it adds illegal-opcode flagging, a sticky halt lock, flush and a saturating decode counter. It sits between instruction fetch and register read/execute.

## Interface
- DATA_W, 20, immediate output width; the 7-bit immediate is sign-extended to this width (must be ≥ 7).
- ADDR_W, 10, address and PC width; the decoded address is zero-extended or truncated to this width (must be ≥ 7).
- CNT_W, 16, width of the decode counter.
- clk  in  1  clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discards all buffered entries and clears the halt lock.
- in_valid / in_ready  in / out  1 / 1  input handshake.
- in_instr  in  20  raw instruction.
- in_pc  in  ADDR_W  PC tag; passed through unchanged.
- out_valid / out_ready  out / in  1 / 1  output handshake.
- out_pc  out  ADDR_W  PC tag of the presented entry.
- alu_select  out  3  ALU operation code.
- alu, is_imm, ld, st, push, pop, jump, be, be_select, halt, illegal  out  1 each  decoded strobes.
- dr, sr1, sr2  out  4 each  register indices.
- imm  out  DATA_W  sign-extended immediate.
- addr  out  ADDR_W  memory/branch address.
- halted  out  1  sticky halt lock.
- decode_count  out  CNT_W  saturating count of entries delivered downstream.

## Operation
- Opcode field is op = instr[19:15].
- op 0: halt.
- op 1–10: ALU instruction.
  - Odd op is register form (regform). Even op sets is_imm.
  - alu_select[2] = (op > 8); alu_select[1] = (op in 5..8); alu_select[0] = (op in {3, 4, 7, 8}).
- op 11 ld, 12 st, 13 push, 14 pop, 15 jump.
- op 16: be with be_select = 1. op 17: be with be_select = 0.
- op 18–31: illegal = 1, all other strobes 0. The entry is still delivered downstream.
- dr source, first match wins:
  - pop → [3:0]
  - ld → [13:10]
  - regform → [11:8]
  - otherwise → [14:11]
- sr1 source, first match wins:
  - push → [3:0]
  - regform → [7:4]
  - ALU immediate form → [10:7]
  - st → [13:10]
  - otherwise → [14:11]
- sr2: regform → [3:0]; otherwise → [10:7].
- addr:
  - be → zero-extended instr[6:0].
  - otherwise → instr[9:0], zero-extended or truncated to ADDR_W.
- imm = sign-extended instr[6:0].
- Every unselected strobe is 0.
- Buffering: a main output register plus one skid register.
  - Decode happens before storage; outputs come straight from the main register.
  - accept = in_valid & in_ready; output transfer = out_valid & out_ready.
  - An input accepted while the main register is occupied and not draining goes to the skid register.
  - The skid register moves into main on the next output transfer.
  - Order is strictly preserved.
- Halt lock: accepting an instruction with op 0 sets halted on the next edge.
  - While halted = 1, in_ready = 0.
  - The halt entry and any entries ahead of it still drain normally.
  - halted is cleared only by flush or reset.
- flush (synchronous):
  - Clears both entries and halted.
  - decode_count is kept.
  - in_ready is forced to 0 during the flush cycle, so nothing is accepted.
- decode_count increments on each output transfer and saturates at 2^CNT_W − 1.

## Timing
- Reset values:
  - out_valid = 0, in_ready = 1, halted = 0, decode_count = 0.
  - All decoded fields and out_pc = 0.
- Latency: accepted in cycle N → out_valid with decoded fields in cycle N+1 when the buffer is empty.
- in_ready = (skid register empty) & ~halted & ~flush.
  - in_ready depends on registered state plus flush only; it never depends on out_ready.
- Throughput: one instruction per cycle while out_ready = 1.
- out_valid and all output fields hold stable while out_valid = 1 and out_ready = 0.
- Simultaneous accept and output transfer with a full main register: the new entry goes to main, or main takes the old skid entry while the new entry goes to skid. The buffer never overflows.
- flush in the same cycle as out_ready: the transfer is not counted, and out_valid = 0 next cycle.
- rst_n falling mid-stream: all state clears immediately (asynchronously).

## Test plan
- Reset, then send 0x08A3C (op 1, regform) with out_ready = 1 → next cycle: alu = 1, is_imm = 0, alu_select = 0, dr = 0xA, sr1 = 0x3, sr2 = 0xC.
- Send op 4 with instr[6:0] = 0x7F, DATA_W = 20 → is_imm = 1, alu_select = 001, imm = 0xFFFFF. Send op 16 with instr[9:0] = 0x3C5 → be = 1, be_select = 1, addr = 0x045.
- Stream 5 instructions with out_ready held 0 → exactly 2 accepted, in_ready = 0. Raise out_ready → entries emerge in order, decode_count = 2.
- Send op 0 followed by valid ops with out_ready = 1 → the halt entry is delivered, halted = 1 and in_ready = 0 from the following cycle. Pulse flush → halted = 0, in_ready = 1.
- Send op 25 → illegal = 1, all other strobes 0. Assert flush while out_valid = 1 and out_ready = 1 → out_valid = 0 next cycle, decode_count unchanged.
- CNT_W = 2: deliver 5 entries → decode_count = 3 (saturated). Assert rst_n low mid-transfer → all outputs return to reset values with no clock edge.
